// File: rtl/pipe_stage_pkg.sv
// Shared definitions for pipeline stage registers built around a skid buffer.
// Stage instances and bench monitors share the same state encoding, so a
// probed state value means the same thing everywhere.
//   ST_EMPTY  2'b00  nothing held
//   ST_BUSY   2'b01  main register valid
//   ST_FULL   2'b11  main and skid registers valid
package pipe_stage_pkg;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'b00,
      ST_BUSY  = 2'b01,
      ST_FULL  = 2'b11
   } state_t;

   // Output-valid is true in every state except EMPTY.
   function automatic logic state_has_data(input state_t st);
      return (st != ST_EMPTY);
   endfunction

endpackage

// File: rtl/pipe_sat_cnt.sv
// Saturating up-counter. It holds at all-ones instead of wrapping, so a long
// stall can never read back as a short one.
// Ports:
//   i_clk      in   1       clock, rising edge
//   i_reset_n  in   1       synchronous active-low clear
//   i_inc      in   1       count this cycle
//   o_count    out  NB_CNT  current count
module pipe_sat_cnt #(
   parameter int NB_CNT = 16
) (
   input  logic              i_clk,
   input  logic              i_reset_n,
   input  logic              i_inc,
   output logic [NB_CNT-1:0] o_count
);

   localparam logic [NB_CNT-1:0] CNT_MAX = '1;

   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         o_count <= '0;
      end else if (i_inc && (o_count != CNT_MAX)) begin
         o_count <= o_count + NB_CNT'(1);
      end
   end

endmodule

// File: rtl/pipe_stage_skid.sv
// Generic pipeline stage register with a valid/ready handshake and a 2-entry
// skid buffer. The upstream ready depends only on registered state, so
// downstream backpressure never has a combinational path to upstream. Also
// provides flush, a debug-unit freeze and a saturating stall counter.
// Ports:
//   i_clk           in   1        clock, rising edge
//   i_reset_n       in   1        synchronous active-low reset
//   i_dunit_clk_en  in   1        0 = freeze (debug halt/step)
//   i_flush         in   1        drop held and incoming data
//   i_in_valid      in   1        upstream has data
//   i_in_data       in   NB_DATA  upstream payload
//   o_in_ready      out  1        stage accepts this cycle
//   o_out_valid     out  1        stage presents payload
//   o_out_data      out  NB_DATA  payload, all-zeros when not valid
//   i_out_ready     in   1        downstream accepts this cycle
//   o_stall_cnt     out  NB_CNT   enabled cycles with valid & !ready
//
// state    | meaning
// ---------+-----------------------------------------------
// ST_EMPTY | nothing held, output is a zero bubble
// ST_BUSY  | main register holds the presented beat
// ST_FULL  | main presented, skid holds the next beat
module pipe_stage_skid
   import pipe_stage_pkg::*;
#(
   parameter int NB_DATA = 64,
   parameter int NB_CNT  = 16
) (
   input  logic               i_clk,
   input  logic               i_reset_n,
   input  logic               i_dunit_clk_en,
   input  logic               i_flush,
   input  logic               i_in_valid,
   input  logic [NB_DATA-1:0] i_in_data,
   output logic               o_in_ready,
   output logic               o_out_valid,
   output logic [NB_DATA-1:0] o_out_data,
   input  logic               i_out_ready,
   output logic [NB_CNT-1:0]  o_stall_cnt
);

   state_t             state;
   logic [NB_DATA-1:0] main_data;
   logic [NB_DATA-1:0] skid_data;
   logic               skid_valid;
   logic               acc;
   logic               take;
   logic               stall_inc;

   assign skid_valid  = (state == ST_FULL);
   assign o_in_ready  = i_reset_n & ~skid_valid & i_dunit_clk_en;
   assign o_out_valid = state_has_data(state);
   // main_data is cleared on every path into EMPTY, so the bubble reads zero.
   assign o_out_data  = main_data;

   // Both terms are gated by the enable, so a freeze falls through to "hold".
   assign acc  = i_in_valid & o_in_ready;
   assign take = o_out_valid & i_out_ready & i_dunit_clk_en;

   assign stall_inc = i_dunit_clk_en & o_out_valid & ~i_out_ready & ~i_flush;

   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         state     <= ST_EMPTY;
         main_data <= '0;
         skid_data <= '0;
      end else if (i_flush) begin
         state     <= ST_EMPTY;
         main_data <= '0;
         skid_data <= '0;
      end else begin
         case (state)
            ST_EMPTY: begin
               if (acc) begin
                  state     <= ST_BUSY;
                  main_data <= i_in_data;
               end
            end
            ST_BUSY: begin
               if (acc && !take) begin
                  state     <= ST_FULL;
                  skid_data <= i_in_data;
               end else if (acc && take) begin
                  main_data <= i_in_data;
               end else if (take) begin
                  state     <= ST_EMPTY;
                  main_data <= '0;
               end
            end
            ST_FULL: begin
               // ready is low here, so only a take can move the state.
               if (take) begin
                  state     <= ST_BUSY;
                  main_data <= skid_data;
                  skid_data <= '0;
               end
            end
            default: begin
               state     <= ST_EMPTY;
               main_data <= '0;
               skid_data <= '0;
            end
         endcase
      end
   end

   pipe_sat_cnt #(
      .NB_CNT (NB_CNT)
   ) u_stall_cnt (
      .i_clk     (i_clk),
      .i_reset_n (i_reset_n),
      .i_inc     (stall_inc),
      .o_count   (o_stall_cnt)
   );

endmodule
